// File: rtl/game_pkg.sv
// ============================================================================
// Module      : game_pkg
// Description : Shared screen bounds, FSM state enumerations and counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

    localparam int c_SCREEN_X_MIN  = 0;
    localparam int c_SCREEN_X_MAX  = 300;
    localparam int c_SCREEN_X_INIT = 150;

    typedef enum logic [0:0] {
        M_IDLE = 1'b0,
        M_HOLD = 1'b1
    } move_state_t;

    typedef enum logic [1:0] {
        F_READY    = 2'd0,
        F_PENDING  = 2'd1,
        F_COOLDOWN = 2'd2
    } fire_state_t;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } dir_t;

    // Bits needed to hold n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/down_counter.sv
// ============================================================================
// Module      : down_counter
// Description : Loadable down counter that stops at zero and flags it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/player_action_scheduler.sv
// ============================================================================
// Module      : player_action_scheduler
// Description : Turns held movement/fire keys into auto-repeating position
//               steps and rate-limited, handshaked shot requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module player_action_scheduler
    import game_pkg::*;
#(
    parameter int X_WIDTH       = 10,
    parameter int X_MIN         = c_SCREEN_X_MIN,
    parameter int X_MAX         = c_SCREEN_X_MAX,
    parameter int X_INIT        = c_SCREEN_X_INIT,
    parameter int MOVE_PERIOD   = 500000,
    parameter int FIRE_COOLDOWN = 12500000,
    parameter int SHOT_OFFSET   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               key_a,
    input  logic               key_d,
    input  logic               key_space,
    input  logic               shot_ready,
    output logic [X_WIDTH-1:0] player_x,
    output logic               move_pulse,
    output logic               shot_valid,
    output logic [X_WIDTH-1:0] shot_x,
    output logic               fire_busy
);

    localparam int c_MOVE_CNT_W = cnt_width(MOVE_PERIOD);
    localparam int c_FIRE_CNT_W = cnt_width(FIRE_COOLDOWN);

    localparam logic [c_MOVE_CNT_W-1:0] c_MOVE_RELOAD  = c_MOVE_CNT_W'(MOVE_PERIOD - 1);
    localparam logic [c_FIRE_CNT_W-1:0] c_FIRE_RELOAD  = c_FIRE_CNT_W'(FIRE_COOLDOWN - 1);
    localparam logic [X_WIDTH-1:0]      c_X_MIN        = X_WIDTH'(X_MIN);
    localparam logic [X_WIDTH-1:0]      c_X_MAX        = X_WIDTH'(X_MAX);
    localparam logic [X_WIDTH-1:0]      c_X_INIT       = X_WIDTH'(X_INIT);
    localparam logic [X_WIDTH-1:0]      c_SHOT_OFFSET  = X_WIDTH'(SHOT_OFFSET);

    move_state_t               r_move_state, w_move_state_next;
    dir_t                      r_dir, w_dir_next, w_dir;
    logic [X_WIDTH-1:0]        r_player_x, w_player_x_next;
    logic                      r_move_pulse, w_move_pulse_next;
    logic                      w_step_req;
    logic                      w_move_load, w_move_en, w_move_zero;
    logic [c_MOVE_CNT_W-1:0]   w_move_load_val;

    fire_state_t               r_fire_state, w_fire_state_next;
    logic                      r_space_prev;
    logic                      w_space_rise;
    logic                      r_shot_valid, w_shot_valid_next;
    logic [X_WIDTH-1:0]        r_shot_x, w_shot_x_next;
    logic                      w_fire_load, w_fire_en, w_fire_zero;

    always_comb begin
        w_dir = DIR_NONE;
        if (key_a && !key_d) begin
            w_dir = DIR_LEFT;
        end else if (key_d && !key_a) begin
            w_dir = DIR_RIGHT;
        end
    end

    // A direction reversal restarts timing exactly like a fresh press.
    always_comb begin
        w_move_state_next = r_move_state;
        w_dir_next        = r_dir;
        w_step_req        = 1'b0;
        w_move_load       = 1'b0;
        w_move_en         = 1'b0;
        w_move_load_val   = c_MOVE_RELOAD;
        case (r_move_state)
            M_IDLE: begin
                if (w_dir != DIR_NONE) begin
                    w_step_req        = 1'b1;
                    w_move_load       = 1'b1;
                    w_dir_next        = w_dir;
                    w_move_state_next = M_HOLD;
                end
            end
            M_HOLD: begin
                if (w_dir == DIR_NONE) begin
                    w_move_state_next = M_IDLE;
                    w_dir_next        = DIR_NONE;
                    w_move_load       = 1'b1;
                    w_move_load_val   = '0;
                end else if (w_dir != r_dir) begin
                    w_step_req  = 1'b1;
                    w_move_load = 1'b1;
                    w_dir_next  = w_dir;
                end else if (w_move_zero) begin
                    w_step_req  = 1'b1;
                    w_move_load = 1'b1;
                end else begin
                    w_move_en = 1'b1;
                end
            end
            default: w_move_state_next = M_IDLE;
        endcase
    end

    always_comb begin
        w_player_x_next   = r_player_x;
        w_move_pulse_next = 1'b0;
        if (w_step_req) begin
            if ((w_dir == DIR_LEFT) && (r_player_x > c_X_MIN)) begin
                w_player_x_next   = r_player_x - 1'b1;
                w_move_pulse_next = 1'b1;
            end else if ((w_dir == DIR_RIGHT) && (r_player_x < c_X_MAX)) begin
                w_player_x_next   = r_player_x + 1'b1;
                w_move_pulse_next = 1'b1;
            end
        end
    end

    assign w_space_rise = key_space && !r_space_prev;

    always_comb begin
        w_fire_state_next = r_fire_state;
        w_shot_valid_next = r_shot_valid;
        w_shot_x_next     = r_shot_x;
        w_fire_load       = 1'b0;
        w_fire_en         = 1'b0;
        case (r_fire_state)
            F_READY: begin
                if (w_space_rise) begin
                    w_shot_x_next     = r_player_x + c_SHOT_OFFSET;
                    w_shot_valid_next = 1'b1;
                    w_fire_state_next = F_PENDING;
                end
            end
            F_PENDING: begin
                if (shot_ready) begin
                    w_shot_valid_next = 1'b0;
                    w_fire_load       = 1'b1;
                    w_fire_state_next = F_COOLDOWN;
                end
            end
            F_COOLDOWN: begin
                if (w_fire_zero) begin
                    w_fire_state_next = F_READY;
                end else begin
                    w_fire_en = 1'b1;
                end
            end
            default: w_fire_state_next = F_READY;
        endcase
    end

    // Space edge register resets high so a key held through reset cannot fire.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_move_state <= M_IDLE;
            r_dir        <= DIR_NONE;
            r_player_x   <= c_X_INIT;
            r_move_pulse <= 1'b0;
            r_fire_state <= F_READY;
            r_space_prev <= 1'b1;
            r_shot_valid <= 1'b0;
            r_shot_x     <= '0;
        end else begin
            r_move_state <= w_move_state_next;
            r_dir        <= w_dir_next;
            r_player_x   <= w_player_x_next;
            r_move_pulse <= w_move_pulse_next;
            r_fire_state <= w_fire_state_next;
            r_space_prev <= key_space;
            r_shot_valid <= w_shot_valid_next;
            r_shot_x     <= w_shot_x_next;
        end
    end

    down_counter #(
        .WIDTH (c_MOVE_CNT_W)
    ) u_repeat_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (w_move_load),
        .enable     (w_move_en),
        .load_value (w_move_load_val),
        .zero       (w_move_zero)
    );

    down_counter #(
        .WIDTH (c_FIRE_CNT_W)
    ) u_cooldown_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (w_fire_load),
        .enable     (w_fire_en),
        .load_value (c_FIRE_RELOAD),
        .zero       (w_fire_zero)
    );

    assign player_x   = r_player_x;
    assign move_pulse = r_move_pulse;
    assign shot_valid = r_shot_valid;
    assign shot_x     = r_shot_x;
    assign fire_busy  = (r_fire_state != F_READY);

endmodule

`default_nettype wire

// File: tb/tb_player_action_scheduler.sv
// ============================================================================
// Module      : tb_player_action_scheduler
// Description : Directed and randomized checks of player_action_scheduler
//               against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_player_action_scheduler;

    localparam int XW   = 10;
    localparam int XMIN = 0;
    localparam int XMAX = 10;
    localparam int XINI = 5;
    localparam int MP   = 4;
    localparam int FC   = 8;
    localparam int OFF  = 2;

    logic          clock      = 1'b0;
    logic          reset      = 1'b1;
    logic          key_a      = 1'b0;
    logic          key_d      = 1'b0;
    logic          key_space  = 1'b0;
    logic          shot_ready = 1'b0;
    logic [XW-1:0] player_x;
    logic          move_pulse;
    logic          shot_valid;
    logic [XW-1:0] shot_x;
    logic          fire_busy;

    player_action_scheduler #(
        .X_WIDTH       (XW),
        .X_MIN         (XMIN),
        .X_MAX         (XMAX),
        .X_INIT        (XINI),
        .MOVE_PERIOD   (MP),
        .FIRE_COOLDOWN (FC),
        .SHOT_OFFSET   (OFF)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .key_a      (key_a),
        .key_d      (key_d),
        .key_space  (key_space),
        .shot_ready (shot_ready),
        .player_x   (player_x),
        .move_pulse (move_pulse),
        .shot_valid (shot_valid),
        .shot_x     (shot_x),
        .fire_busy  (fire_busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: position, held direction (-1/0/+1) with edges since its
    // last step, and the edge index of the latest shot handshake.
    int m_x, m_sx, m_held, m_age, m_hs;
    int edge_n = 0;
    bit m_pulse, m_sv, m_busy, m_pend, m_prev_space;
    bit chk_en = 1'b0;

    always @(posedge clock) begin
        int dir;
        int tgt;
        bit step;
        edge_n++;
        if (reset) begin
            m_x = XINI; m_sx = 0; m_pulse = 0; m_sv = 0; m_busy = 0; m_pend = 0;
            m_held = 0; m_age = 0; m_prev_space = 1; m_hs = -1000;
            chk_en = 1'b1;
        end else begin
            dir = (key_a && !key_d) ? -1 : ((key_d && !key_a) ? 1 : 0);
            if (m_pend) begin
                if (shot_ready) begin
                    m_pend = 0; m_sv = 0; m_hs = edge_n;
                end
            end else if (!m_busy && key_space && !m_prev_space) begin
                m_pend = 1; m_sv = 1; m_sx = (m_x + OFF) % (1 << XW);
            end
            m_busy       = m_pend || (edge_n < m_hs + FC);
            m_prev_space = key_space;
            m_pulse = 0;
            step    = 0;
            if (dir == 0) begin
                m_held = 0;
            end else if (dir != m_held) begin
                step = 1; m_held = dir; m_age = 0;
            end else begin
                m_age++;
                if (m_age == MP) begin
                    step = 1; m_age = 0;
                end
            end
            if (step) begin
                tgt = m_x + dir;
                if (tgt >= XMIN && tgt <= XMAX) begin
                    m_x = tgt; m_pulse = 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("player_x",   player_x,   m_x);
            check("move_pulse", move_pulse, m_pulse);
            check("shot_valid", shot_valid, m_sv);
            check("shot_x",     shot_x,     m_sx);
            check("fire_busy",  fire_busy,  m_busy);
        end
    end

    initial begin
        int cnt_a;
        int cnt_b;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_player_x",   player_x,   5);
        check("rst_move_pulse", move_pulse, 0);
        check("rst_shot_valid", shot_valid, 0);
        check("rst_shot_x",     shot_x,     0);
        check("rst_fire_busy",  fire_busy,  0);
        reset = 1'b0;
        @(negedge clock);

        // Shot with delayed ready, then a dropped press during cooldown
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 20; k++) begin
            key_space  = (k < 2) || (k == 9);
            shot_ready = (k >= 6);
            @(negedge clock);
            if (k == 0) begin
                check("first_shot_x", shot_x, 7);
                check("model_shot_x", m_sx, 7);
            end
            cnt_a += int'(shot_valid);
            cnt_b += int'(fire_busy);
        end
        check("shot_valid_cycles", cnt_a, 6);
        check("fire_busy_cycles",  cnt_b, 14);
        key_space = 1'b1;
        @(negedge clock);
        check("shot_after_cooldown", shot_valid, 1);
        key_space = 1'b0;
        repeat (10) @(negedge clock);

        // Auto-repeat right from 5
        key_d = 1'b1; cnt_a = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (k == 0) check("first_step_x", player_x, 6);
            cnt_a += int'(move_pulse);
        end
        check("repeat_pulses", cnt_a, 3);
        check("repeat_x", player_x, 8);
        check("model_repeat_x", m_x, 8);
        key_d = 1'b0;
        @(negedge clock);

        // Walk to the right edge, then hold against it
        repeat (2) begin
            key_d = 1'b1; @(negedge clock);
            key_d = 1'b0; @(negedge clock);
        end
        check("at_max_x", player_x, 10);
        key_d = 1'b1; cnt_a = 0;
        repeat (12) begin
            @(negedge clock);
            cnt_a += int'(move_pulse);
        end
        check("edge_pulses", cnt_a, 0);
        check("edge_x", player_x, 10);
        key_d = 1'b0;
        @(negedge clock);

        // Both keys cancel; releasing one steps at once
        key_a = 1'b1; key_d = 1'b1;
        repeat (3) @(negedge clock);
        check("both_keys_x", player_x, 10);
        key_d = 1'b0;
        @(negedge clock);
        check("release_d_x", player_x, 9);
        check("release_d_pulse", move_pulse, 1);
        key_a = 1'b0;
        @(negedge clock);

        // Reset during a pending shot with space held
        shot_ready = 1'b0; key_space = 1'b1;
        @(negedge clock);
        check("pending_before_reset", shot_valid, 1);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("reset_shot_valid", shot_valid, 0);
        check("reset_player_x", player_x, 5);
        check("reset_fire_busy", fire_busy, 0);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check("no_replay_after_reset", shot_valid, 0);
        key_space = 1'b0;
        @(negedge clock);
        key_space = 1'b1;
        @(negedge clock);
        check("repress_after_reset", shot_valid, 1);
        key_space = 1'b0; shot_ready = 1'b1;
        repeat (12) @(negedge clock);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) key_a = ~key_a;
            if ($urandom_range(0, 5) == 0) key_d = ~key_d;
            if ($urandom_range(0, 3) == 0) key_space = ~key_space;
            shot_ready = ($urandom_range(0, 2) != 0);
            reset      = ($urandom_range(0, 299) == 0);
            @(negedge clock);
        end
        reset = 1'b0;
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/player_action_scheduler.md
PLAYER_ACTION_SCHEDULER -- requirements
Module: player_action_scheduler

Interface
REQ-001 Parameter X_WIDTH, default 10: width of the player and shot x coordinates.
REQ-002 Parameter X_MIN, default 0: leftmost legal player_x.
REQ-003 Parameter X_MAX, default 300: rightmost legal player_x.
REQ-004 Parameter X_INIT, default 150: player_x after reset.
REQ-005 Parameter MOVE_PERIOD, default 500000: cycles between auto-repeat steps while a direction is held; legal range 2 or more.
REQ-006 Parameter FIRE_COOLDOWN, default 12500000: cycles after a shot handshake before the next shot may issue; legal range 1 or more.
REQ-007 Parameter SHOT_OFFSET, default 8: added to player_x to form shot_x.
REQ-008 clock  input  1  single clock; all logic on its rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 key_a  input  1  level: A key held (move left).
REQ-011 key_d  input  1  level: D key held (move right).
REQ-012 key_space  input  1  level: space held (fire).
REQ-013 shot_ready  input  1  shot consumer accepts shot this cycle.
REQ-014 player_x  output  X_WIDTH  registered player position.
REQ-015 move_pulse  output  1  one-cycle strobe, high in the cycle player_x shows a new value.
REQ-016 shot_valid  output  1  shot request pending.
REQ-017 shot_x  output  X_WIDTH  shot spawn x; stable while shot_valid is high.
REQ-018 fire_busy  output  1  high while the fire FSM is in PENDING or COOLDOWN.

Function
REQ-019 Direction: exactly one of key_a and key_d high is LEFT or RIGHT; both high or both low is NONE.
REQ-020 Move FSM states: M_IDLE, M_HOLD. M_IDLE with direction not NONE: step once (player_x and move_pulse update on the next edge), load the repeat counter with MOVE_PERIOD-1, enter M_HOLD.
REQ-021 M_HOLD, direction unchanged: decrement the counter; on the cycle it reads 0, step and reload MOVE_PERIOD-1.
REQ-022 M_HOLD, direction changes to the opposite: treat as a new press (immediate step, counter reload); direction becomes NONE: return to M_IDLE and clear the counter.
REQ-023 Step: LEFT subtracts 1 and RIGHT adds 1; a step that would leave [X_MIN, X_MAX] leaves player_x unchanged and suppresses move_pulse. Timing continues unchanged.
REQ-024 Fire FSM states: F_READY, F_PENDING, F_COOLDOWN.
REQ-025 F_READY: a key_space rising edge (registered previous sample low, current high) captures shot_x = player_x + SHOT_OFFSET (current register value, before any same-cycle step), asserts shot_valid on the next edge, and enters F_PENDING.
REQ-026 F_PENDING: shot_valid and shot_x hold until shot_valid and shot_ready are both high on an edge. That edge deasserts shot_valid, loads the cooldown counter with FIRE_COOLDOWN-1, and enters F_COOLDOWN.
REQ-027 F_COOLDOWN: decrement every cycle; at count 0 go to F_READY.
REQ-028 A space edge in F_PENDING or F_COOLDOWN is dropped, not queued; holding space does not auto-fire.
REQ-029 Movement and firing are independent; both may update in the same cycle.
REQ-030 shot_x is truncated to X_WIDTH bits with no saturation; integrators keep X_MAX + SHOT_OFFSET within range.

Reset
REQ-031 reset high at an edge: player_x = X_INIT; move_pulse, shot_valid and fire_busy = 0; shot_x = 0.
REQ-032 Reset also forces M_IDLE and F_READY, zeroes both counters, and sets the space edge register to 1, so a key held through reset does not fire.
REQ-033 Reset wins over all concurrent events, including a pending shot handshake; a shot dropped by reset is not replayed.

Structure
REQ-034 Shared package game_pkg holds the move and fire state enumerations and the screen-bound constants used for X_MIN, X_MAX and X_INIT defaults.
REQ-035 One sub-module, down_counter (load, enable, zero flag, width from parameter), is instantiated twice: repeat timer and cooldown timer.

Verification (MOVE_PERIOD=4, FIRE_COOLDOWN=8, X_MIN=0, X_MAX=10, X_INIT=5, SHOT_OFFSET=2)
REQ-036 Hold key_d for 10 cycles -> player_x goes 6 one cycle after the press, then 7 and 8 every 4 cycles; move_pulse pulses 3 times.
REQ-037 From player_x=10, hold key_d 12 cycles -> player_x stays 10, move_pulse never asserts.
REQ-038 Press space with shot_ready low for 5 cycles, then high -> shot_valid high for 6 cycles with shot_x=7; fire_busy high from the first shot_valid cycle until 8 cycles after the handshake.
REQ-039 Second space press 3 cycles after the handshake -> no shot_valid; a press after fire_busy falls issues a shot.
REQ-040 key_a and key_d both high -> no movement; release key_d -> immediate left step.
REQ-041 Assert reset while shot_valid=1 and key_space held -> all outputs at reset values, no shot after reset deasserts until space is released and pressed again.
